mag_window_stats: RTL
=====================

MAG_WINDOW_STATS -- requirements
Module: mag_window_stats

Interface
REQ-001 Parameter WIN_LOG2, default 3, SHALL set window length N = 2**WIN_LOG2 accepted samples (legal 1..4).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: synchronous and active-low.
REQ-004 Port ena, input, 1, SHALL be the global enable; when low, all state SHALL hold and stats_valid SHALL be 0.
REQ-005 Port mag_valid, input, 1, SHALL qualify mag_in; a sample is accepted when ena && mag_valid && !clear.
REQ-006 Port mag_in, input, 8, SHALL carry the unsigned magnitude from the upstream magnitude stage.
REQ-007 Port thr_hi, input, 8, SHALL be the unsigned alarm-assert threshold.
REQ-008 Port thr_lo, input, 8, SHALL be the unsigned alarm-release threshold.
REQ-009 Port clear, input, 1, SHALL synchronously discard the partial window and return the alarm FSM to QUIET (gated by ena).
REQ-010 Port avg_out, output, 8, SHALL hold the floor mean of the last completed window.
REQ-011 Port peak_out, output, 8, SHALL hold the maximum of the last completed window.
REQ-012 Port stats_valid, output, 1, SHALL pulse high for exactly one cycle when avg_out/peak_out update.
REQ-013 Port alarm, output, 1, SHALL be registered, high in FSM states ALARM and FALLING.
REQ-014 Port win_cnt, output, 4, SHALL show accepted samples in the current partial window (0..N-1).

Function
REQ-015 Accumulator SHALL be 8+WIN_LOG2 bits wide; no overflow possible; avg = sum >> WIN_LOG2 (truncating).
REQ-016 Running peak SHALL compare unsigned, mag_in >= peak replaces peak.
REQ-017 On the Nth accepted sample, the edge that accepts it SHALL load avg_out/peak_out including that sample, set stats_valid for the following cycle, and zero sum, peak and win_cnt; latency 1 cycle from accept.
REQ-018 Windows SHALL be back-to-back non-overlapping; a sample in the cycle after completion starts the next window with no gap.
REQ-019 avg_out/peak_out SHALL hold between completions, including across clear.
REQ-020 Alarm FSM states QUIET, RISING, ALARM, FALLING SHALL transition only on accepted samples; hi = mag_in >= thr_hi, lo = mag_in <= thr_lo.
REQ-021 QUIET: hi -> RISING, else stay; RISING: hi -> ALARM, else QUIET.
REQ-022 ALARM: lo -> FALLING, else stay; FALLING: lo -> QUIET, else ALARM.
REQ-023 QUIET/RISING SHALL evaluate only hi; ALARM/FALLING only lo (defines behaviour when thr_lo >= thr_hi).
REQ-024 alarm SHALL change on the edge that takes the FSM into/out of {ALARM, FALLING}.
REQ-025 clear with mag_valid same cycle: clear wins, sample dropped, stats_valid 0 next cycle.
REQ-026 Threshold changes SHALL take effect on the next accepted sample; no retroactive evaluation.

Reset
REQ-027 With rst_n low at an edge: avg_out, peak_out, win_cnt, sum, running peak = 0; stats_valid = 0; alarm = 0; FSM = QUIET; regardless of ena.
REQ-028 Reset mid-window SHALL discard the partial window; first post-reset accepted sample is sample 1 of a new window.

Structure
REQ-029 Shared package mag_pkg SHALL hold the FSM state enum (2-bit) and MAG_W = 8.
REQ-030 Alarm FSM SHALL be sub-module mag_alarm_fsm (inputs: accept, hi, lo, clear; output: alarm); windowing logic stays in the top.

Verification
REQ-031 N=8, samples 10,20,30,40,50,60,70,80 consecutive -> one cycle after 8th: avg_out=45, peak_out=80, stats_valid one-cycle pulse, win_cnt=0.
REQ-032 Eight samples of 255 -> avg_out=255, peak_out=255 (no overflow); next window 1..8 -> avg_out=4, peak_out=8.
REQ-033 thr_hi=100, thr_lo=50: samples 120,40,120,120 -> alarm rises after 4th; then 30,60,30,30 -> alarm falls after last.
REQ-034 Three samples accepted, then clear with mag_valid high -> win_cnt=0, sample dropped, prior avg_out/peak_out held, FSM QUIET.
REQ-035 ena low for 5 cycles with mag_valid high mid-window -> no state change, stats_valid 0; resume completes window on correct count.
REQ-036 rst_n low for one edge with win_cnt=5 and alarm=1 -> all outputs 0 next cycle; 8 new samples needed for next stats_valid.

Source files
------------

// File: rtl/mag_pkg.sv
// Shared definitions for the magnitude window statistics block.
package mag_pkg;

    localparam int MAG_W = 8;

    // Encoded so the alarm output is simply bit 1 of the state register.
    typedef enum logic [1:0] {
        QUIET   = 2'b00,
        RISING  = 2'b01,
        ALARM   = 2'b11,
        FALLING = 2'b10
    } alarm_state_t;

    function automatic logic is_alarm(input alarm_state_t s);
        return (s == ALARM) || (s == FALLING);
    endfunction

endpackage

// File: rtl/mag_alarm_fsm.sv
// Hysteresis alarm FSM: two consecutive hi samples assert, two consecutive lo samples release.
module mag_alarm_fsm
    import mag_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic hi,
    input  logic lo,
    input  logic clear,
    output logic alarm
);

    alarm_state_t state;
    alarm_state_t state_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= QUIET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = QUIET;
        end else if (accept) begin
            case (state)
                QUIET:   state_next = hi ? RISING  : QUIET;
                RISING:  state_next = hi ? ALARM   : QUIET;
                ALARM:   state_next = lo ? FALLING : ALARM;
                FALLING: state_next = lo ? QUIET   : ALARM;
                default: state_next = QUIET;
            endcase
        end
    end

    always_comb begin
        alarm = is_alarm(state);
    end

endmodule

// File: rtl/mag_window_stats.sv
// Non-overlapping 2**WIN_LOG2-sample window mean/peak of a magnitude stream, plus hysteresis alarm.
module mag_window_stats
    import mag_pkg::*;
#(
    parameter int WIN_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mag_valid,
    input  logic [MAG_W-1:0] mag_in,
    input  logic [MAG_W-1:0] thr_hi,
    input  logic [MAG_W-1:0] thr_lo,
    input  logic             clear,
    output logic [MAG_W-1:0] avg_out,
    output logic [MAG_W-1:0] peak_out,
    output logic             stats_valid,
    output logic             alarm,
    output logic [3:0]       win_cnt
);

    localparam int SUM_W = MAG_W + WIN_LOG2;

    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;
    logic [MAG_W-1:0]    peak;
    logic [MAG_W-1:0]    peak_next;
    logic [WIN_LOG2-1:0] cnt;
    logic                accept;
    logic                clear_en;
    logic                last;
    logic                stats_q;
    logic                hi;
    logic                lo;

    always_comb begin
        clear_en  = ena && clear;
        accept    = ena && mag_valid && !clear;
        last      = &cnt;
        sum_next  = sum + SUM_W'(mag_in);
        peak_next = (mag_in >= peak) ? mag_in : peak;
        hi        = mag_in >= thr_hi;
        lo        = mag_in <= thr_lo;
    end

    // Completing sample is folded into the published stats on the same edge,
    // and the accumulators restart so the next cycle can open a new window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum      <= '0;
            peak     <= '0;
            cnt      <= '0;
            avg_out  <= '0;
            peak_out <= '0;
            stats_q  <= 1'b0;
        end else begin
            stats_q <= 1'b0;
            if (clear_en) begin
                sum  <= '0;
                peak <= '0;
                cnt  <= '0;
            end else if (accept) begin
                if (last) begin
                    avg_out  <= sum_next[SUM_W-1 -: MAG_W];
                    peak_out <= peak_next;
                    stats_q  <= 1'b1;
                    sum      <= '0;
                    peak     <= '0;
                    cnt      <= '0;
                end else begin
                    sum  <= sum_next;
                    peak <= peak_next;
                    cnt  <= cnt + WIN_LOG2'(1);
                end
            end
        end
    end

    always_comb begin
        stats_valid = stats_q && ena;
        win_cnt     = 4'(cnt);
    end

    mag_alarm_fsm u_alarm_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .hi     (hi),
        .lo     (lo),
        .clear  (clear_en),
        .alarm  (alarm)
    );

endmodule
